// File: rtl/rgb_pwm_ctr_pkg.sv
// Purpose : shared types and constants for the multi-LED RGB PWM driver.
// Latency : n/a (types only).
// Backpressure: n/a.
package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } rgb_mode_t;

    // Level is kept outside the struct because its width follows PWM_BITS.
    typedef struct packed {
        logic [2:0] color;
        rgb_mode_t  mode;
    } rgb_cfg_t;

    localparam int RGB_R = 0;
    localparam int RGB_G = 1;
    localparam int RGB_B = 2;

    localparam rgb_cfg_t CFG_RESET = '{color: 3'b000, mode: MODE_OFF};

    // Index port width; a single-LED build still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_ctr_if.sv
// Purpose : configuration write port (valid/ready) for rgb_pwm_ctr.
// Latency : n/a (wiring only).
// Backpressure: ready comes from the slave; master holds fields while valid.
interface rgb_pwm_ctr_if
    import rgb_pkg::*;
#(
    parameter int IDX_W    = 1,
    parameter int PWM_BITS = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [IDX_W-1:0]    cfg_idx;
    logic [2:0]          cfg_color;
    rgb_mode_t           cfg_mode;
    logic [PWM_BITS-1:0] cfg_level;

    modport master (
        output cfg_valid, cfg_idx, cfg_color, cfg_mode, cfg_level,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_color, cfg_mode, cfg_level,
        output cfg_ready
    );
endinterface

// File: rtl/rgb_pwm_ctr_chan.sv
// Purpose : one RGB LED: shadow/active config, duty mux, PWM compare, output flop.
// Latency : shadow->active at period boundary, output one clock after compare.
// Backpressure: none; every write strobe lands in the shadow register.
// Ports   : wr_en/wr_cfg/wr_level shadow write, load = period boundary,
//           pwm_cnt/ramp/blink_ph shared timebase, led = registered colour bits.
module rgb_pwm_chan
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8
)
(
    input  logic                clk_in,
    input  logic                reset,
    input  logic                wr_en,
    input  rgb_cfg_t            wr_cfg,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic                load,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] ramp,
    input  logic                blink_ph,
    output logic [2:0]          led
);
    rgb_cfg_t                shd_cfg;
    rgb_cfg_t                act_cfg;
    logic [PWM_BITS-1:0]     shd_level;
    logic [PWM_BITS-1:0]     act_level;
    logic [PWM_BITS-1:0]     duty;
    logic [2*PWM_BITS-1:0]   breathe_prod;
    logic                    on;

    // A write on the load cycle only reaches the shadow; active takes the
    // previous shadow contents and sees the new write one period later.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shd_cfg   <= CFG_RESET;
            shd_level <= '0;
            act_cfg   <= CFG_RESET;
            act_level <= '0;
        end else begin
            if (wr_en) begin
                shd_cfg   <= wr_cfg;
                shd_level <= wr_level;
            end
            if (load) begin
                act_cfg   <= shd_cfg;
                act_level <= shd_level;
            end
        end
    end

    // Full-width product, then keep the top half: ramp scales level.
    assign breathe_prod = {{PWM_BITS{1'b0}}, ramp} * {{PWM_BITS{1'b0}}, act_level};

    always_comb begin
        duty = '0;
        case (act_cfg.mode)
            MODE_OFF:     duty = '0;
            MODE_SOLID:   duty = act_level;
            MODE_BLINK:   duty = blink_ph ? act_level : '0;
            MODE_BREATHE: duty = breathe_prod[2*PWM_BITS-1:PWM_BITS];
            default:      duty = '0;
        endcase
    end

    // Strict compare: duty 0 never lights, full-scale duty misses one slot.
    assign on = (pwm_cnt < duty);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            led <= 3'b000;
        end else begin
            led <= act_cfg.color & {3{on}};
        end
    end
endmodule

// File: rtl/rgb_pwm_ctr.sv
// Purpose : N-LED RGB driver with per-LED colour, level and off/solid/blink/breathe mode.
// Latency : config applies at next PWM boundary; led_out changes one clock later.
// Backpressure: none; cfg_ready is high whenever reset is released.
// Ports   : clk_in, reset (async active-low), cfg (slave config port),
//           led_out (LED i on bits [3i+2:3i], bit0 red, bit1 green, bit2 blue).
module rgb_pwm_ctr
    import rgb_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int N_LEDS      = 2,
    parameter int PWM_BITS    = 8,
    parameter int PWM_HZ      = 1000,
    parameter int BLINK_HZ    = 2
)
(
    input  logic                  clk_in,
    input  logic                  reset,
    rgb_pwm_ctr_if.slave          cfg,
    output logic [3*N_LEDS-1:0]   led_out
);
    localparam int PWM_DIV   = CLK_FREQ_HZ / (PWM_HZ * (2 ** PWM_BITS));
    localparam int BLINK_MAX = CLK_FREQ_HZ / (2 * BLINK_HZ) - 1;
    localparam int PRE_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W     = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;
    localparam int IDX_W     = idx_width(N_LEDS);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_MAX);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

    if (N_LEDS < 1) begin : g_bad_n_leds
        $error("rgb_pwm_ctr: N_LEDS must be >= 1");
    end
    if (PWM_BITS < 2) begin : g_bad_pwm_bits
        $error("rgb_pwm_ctr: PWM_BITS must be >= 2");
    end
    if (PWM_DIV < 1) begin : g_bad_pwm_div
        $error("rgb_pwm_ctr: CLK_FREQ_HZ too low for PWM_HZ * 2**PWM_BITS");
    end
    if (BLINK_MAX < 0) begin : g_bad_blink
        $error("rgb_pwm_ctr: BLINK_HZ too high for CLK_FREQ_HZ");
    end
    if ($bits(cfg.cfg_idx) != IDX_W) begin : g_bad_idx_w
        $error("rgb_pwm_ctr: cfg interface IDX_W does not match N_LEDS");
    end

    logic [PRE_W-1:0]    pwm_pre;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_tick;
    logic                boundary;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_ph;
    logic [PWM_BITS-1:0] ramp;
    logic                ramp_up;
    logic                cfg_fire;
    rgb_cfg_t            wr_cfg;

    assign pwm_tick = (pwm_pre == PRE_LAST);
    assign boundary = pwm_tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pwm_pre <= '0;
            pwm_cnt <= '0;
        end else if (pwm_tick) begin
            pwm_pre <= '0;
            pwm_cnt <= pwm_cnt + CNT_ONE;
        end else begin
            pwm_pre <= pwm_pre + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // Triangle 0..max..0 without repeating endpoints: turn around on the
    // endpoint and step away in the same cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (boundary) begin
            if (ramp_up) begin
                if (ramp == CNT_MAX) begin
                    ramp_up <= 1'b0;
                    ramp    <= ramp - CNT_ONE;
                end else begin
                    ramp    <= ramp + CNT_ONE;
                end
            end else begin
                if (ramp == '0) begin
                    ramp_up <= 1'b1;
                    ramp    <= ramp + CNT_ONE;
                end else begin
                    ramp    <= ramp - CNT_ONE;
                end
            end
        end
    end

    assign cfg.cfg_ready = reset;
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_cfg        = '{color: cfg.cfg_color, mode: cfg.cfg_mode};

    // Out-of-range indices match no channel, so the write is silently dropped.
    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        logic wr_en;
        assign wr_en = cfg_fire && (cfg.cfg_idx == IDX_W'(i));

        rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .clk_in   (clk_in),
            .reset    (reset),
            .wr_en    (wr_en),
            .wr_cfg   (wr_cfg),
            .wr_level (cfg.cfg_level),
            .load     (boundary),
            .pwm_cnt  (pwm_cnt),
            .ramp     (ramp),
            .blink_ph (blink_ph),
            .led      (led_out[3*i +: 3])
        );
    end
endmodule

// File: tb/tb_rgb_pwm_ctr.sv
// Purpose : directed bench for rgb_pwm_ctr (1024 Hz clock, 4-bit PWM, 16-clock period, 64-clock blink half).
// Latency : expectations are written in edges counted from reset release.
// Backpressure: cfg_ready is expected high whenever reset is released.
module tb_rgb_pwm_ctr;
    import rgb_pkg::*;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [5:0] led_out;
    int         cyc;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         hi0;
    int         hi1;
    int         bad;
    int         bad_tot;

    // Per-period lit count while breathing at level 15, ramp 0..15..1.
    int breathe_exp [30] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14,
                             13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    rgb_pwm_ctr_if #(.IDX_W(1), .PWM_BITS(4)) cfg ();

    rgb_pwm_ctr #(
        .CLK_FREQ_HZ (1024),
        .N_LEDS      (2),
        .PWM_BITS    (4),
        .PWM_HZ      (64),
        .BLINK_HZ    (8)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .cfg     (cfg),
        .led_out (led_out)
    );

    always #5 clk_in = ~clk_in;

    // Edge number since reset release; after edge E, cyc == E.
    always @(posedge clk_in or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Move to the falling edge that follows rising edge e.
    task automatic goto(input int e);
        int guard = 0;
        while (cyc < e && guard < 4000) begin
            @(negedge clk_in);
            guard++;
        end
        if (cyc != e) check_vec("align", cyc, e);
    endtask

    task automatic cfg_write(input int at, input logic idx, input logic [2:0] color,
                             input rgb_mode_t mode, input logic [3:0] level);
        goto(at);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_idx   = idx;
        cfg.cfg_color = color;
        cfg.cfg_mode  = mode;
        cfg.cfg_level = level;
        goto(at + 1);
        cfg.cfg_valid = 1'b0;
    endtask

    // Count edges in [from,to] where each LED shows its expected colour;
    // any other non-zero value counts as bad.
    task automatic scan(input int from, input int to, input logic [2:0] v0, input logic [2:0] v1);
        hi0 = 0;
        hi1 = 0;
        bad = 0;
        for (int e = from; e <= to; e++) begin
            goto(e);
            if (led_out[2:0] == v0)          hi0++;
            else if (led_out[2:0] != 3'b000) bad++;
            if (led_out[5:3] == v1)          hi1++;
            else if (led_out[5:3] != 3'b000) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d expected end", cyc);
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_idx   = 1'b0;
        cfg.cfg_color = 3'b000;
        cfg.cfg_mode  = MODE_OFF;
        cfg.cfg_level = 4'd0;
        #1;
        check_vec("rst_led_out", int'(led_out), 0);
        check_vec("rst_ready", int'(cfg.cfg_ready), 0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;

        // 1: idle after release
        goto(1);
        check_vec("idle_ready", int'(cfg.cfg_ready), 1);
        check_vec("idle_led_out", int'(led_out), 0);
        scan(2, 16, 3'b111, 3'b111);
        check_vec("idle_dark", hi0 + hi1 + bad, 0);

        // 2: LED0 red solid level 4, written mid-period (accepted edge 21)
        cfg_write(20, 1'b0, 3'b001, MODE_SOLID, 4'd4);
        scan(22, 32, 3'b001, 3'b111);
        check_vec("solid_before_bnd", hi0 + bad, 0);
        scan(33, 36, 3'b001, 3'b111);
        check_vec("solid_first_slots", hi0, 4);
        scan(37, 48, 3'b001, 3'b111);
        check_vec("solid_rest_dark", hi0, 0);
        check_vec("solid_other_bits", bad + hi1, 0);

        // 3: LED1 white blink level 15 (accepted edge 51, active at 64)
        cfg_write(50, 1'b1, 3'b111, MODE_BLINK, 4'd15);
        scan(52, 64, 3'b001, 3'b111);
        check_vec("blink_before_bnd", hi1, 0);
        scan(65, 128, 3'b001, 3'b111);
        check_vec("blink_on_half", hi1, 60);
        check_vec("blink_led0_solid", hi0, 16);
        scan(129, 192, 3'b001, 3'b111);
        check_vec("blink_off_half", hi1, 0);
        check_vec("blink_off_led0", hi0, 16);
        scan(193, 208, 3'b001, 3'b111);
        check_vec("blink_on_period", hi1, 15);
        check_vec("blink_bad", bad, 0);

        // 4: LED0 green breathe level 15, active at edge 480 where ramp is 0
        cfg_write(470, 1'b0, 3'b010, MODE_BREATHE, 4'd15);
        bad_tot = 0;
        for (int p = 0; p < 30; p++) begin
            scan(481 + 16 * p, 496 + 16 * p, 3'b010, 3'b111);
            check_vec($sformatf("breathe_p%0d", p), hi0, breathe_exp[p]);
            bad_tot += bad;
        end
        check_vec("breathe_bad", bad_tot, 0);

        // 5: two LED0 writes in one period, LED1 write on the boundary edge 976
        cfg_write(965, 1'b0, 3'b001, MODE_SOLID, 4'd2);
        cfg_write(966, 1'b0, 3'b001, MODE_SOLID, 4'd9);
        cfg_write(975, 1'b1, 3'b100, MODE_SOLID, 4'd5);
        scan(977, 992, 3'b001, 3'b111);
        check_vec("last_write_wins", hi0, 9);
        check_vec("bnd_write_held", hi1, 15);
        check_vec("bnd_period_bad", bad, 0);
        scan(993, 1008, 3'b001, 3'b100);
        check_vec("led0_next_period", hi0, 9);
        check_vec("bnd_write_applied", hi1, 5);
        check_vec("applied_bad", bad, 0);

        // 6: reset mid-period while both lit, with a pending shadow write
        goto(1010);
        check_vec("both_lit_a", int'(led_out), 6'b100001);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_idx   = 1'b0;
        cfg.cfg_color = 3'b111;
        cfg.cfg_mode  = MODE_SOLID;
        cfg.cfg_level = 4'd15;
        goto(1011);
        cfg.cfg_valid = 1'b0;
        check_vec("both_lit_b", int'(led_out), 6'b100001);
        #2;
        reset = 1'b0;
        #1;
        check_vec("async_clear", int'(led_out), 0);
        check_vec("async_ready", int'(cfg.cfg_ready), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;

        cfg_write(2, 1'b1, 3'b111, MODE_BLINK, 4'd15);
        check_vec("rerelease_ready", int'(cfg.cfg_ready), 1);
        scan(4, 64, 3'b111, 3'b111);
        check_vec("post_rst_led0_dark", hi0, 0);
        check_vec("post_rst_blink_dark", hi1, 0);
        check_vec("post_rst_bad", bad, 0);
        scan(65, 80, 3'b111, 3'b111);
        check_vec("post_rst_blink_on", hi1, 15);
        check_vec("post_rst_led0_off", hi0 + bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rgb_pwm_ctr.md
# rgb_pwm_ctr

Multi-LED RGB driver that generalises the single-LED on/blink controller. It adds per-LED colour, brightness (PWM) and mode (off/solid/blink/breathe), all programmed through a valid/ready configuration port. Configuration changes are double-buffered, so an LED's output never glitches mid PWM period. The block sits between the calculator's control logic and the board RGB LED pins.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: input clock frequency.
- `N_LEDS`, 2: number of RGB LEDs; must be ≥1.
- `PWM_BITS`, 8: PWM resolution, B; must be ≥2.
- `PWM_HZ`, 1000: PWM period rate; `PWM_DIV = CLK_FREQ_HZ/(PWM_HZ*2**B)`, must be ≥1 (elaboration assertion).
- `BLINK_HZ`, 2: blink rate; half-period `BLINK_MAX = CLK_FREQ_HZ/(2*BLINK_HZ)-1` clocks.

Ports:
- `clk_in` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: block accepts config; a write occurs when `cfg_valid & cfg_ready`.
- `cfg_idx` in `$clog2(N_LEDS)` (min 1): target LED.
- `cfg_color` in 3: colour enables; bit2 blue, bit1 green, bit0 red.
- `cfg_mode` in 2: 0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE.
- `cfg_level` in B: brightness.
- `led_out` out 3*N_LEDS: LED i occupies `[3i+2:3i]`, same bit order as `cfg_color`.

## Operation
- **Shadow registers.** Each LED has a shadow register (color, mode, level) and an active register. An accepted write lands in shadow[cfg_idx] at that clock edge. A write with `cfg_idx ≥ N_LEDS` is accepted and dropped.
- **Active copy.** All active registers copy from their shadows on the cycle `pwm_cnt` wraps from 2^B-1 to 0, the PWM period boundary.
- **Write on the boundary.** A write accepted on the boundary cycle updates shadow only and reaches active at the next boundary.
- **Back-to-back writes.** Multiple writes within one period: the last write to each LED wins.
- **`cfg_ready`.** 0 while `reset` is asserted, 1 at all other times. The block has no backpressure.
- **Prescaler.** `pwm_pre` counts 0..PWM_DIV-1; `pwm_tick` pulses on its wrap. `pwm_cnt` (B bits) increments on each `pwm_tick` and wraps.
- **Blink counter.** Counts 0..BLINK_MAX and toggles `blink_ph` on wrap. All LEDs share it.
- **Breathe ramp.** `ramp` (B bits) plus a direction bit step once per PWM period boundary.
  - Counts up from 0 to 2^B-1, then down to 0, repeating.
  - Reverses at the endpoints with no repeat of the endpoint values.
- **Timebase.** All counters free-run regardless of mode.
- **Duty per active mode:**
  - OFF: 0.
  - SOLID: level.
  - BLINK: `blink_ph ? level : 0`.
  - BREATHE: `(ramp*level) >> B`, computed with a 2B-bit product then truncated.
- **Output.** `on = (pwm_cnt < duty)`, so duty 0 is always dark and duty 2^B-1 is lit for 2^B-1 of 2^B slots. `led_out` for LED i is `color & {3{on}}`, registered.
- **Reset values** (all asynchronous, active-low):
  - `led_out = 0`.
  - All counters 0, `blink_ph = 0`, direction = up.
  - Shadow and active registers: color 0, mode OFF, level 0.
- **Reset release.** Counting begins on the first `clk_in` edge after release.
- **Reset mid-operation.** Clears everything immediately, including pending shadow writes.

## Timing
- **Write-to-output latency.** A write accepted at edge k is applied at the next boundary edge b > k. The first changed `led_out` value appears at edge b+1, because the output register adds one cycle.
- **PWM period.** PWM_DIV·2^B clocks.
- **Blink period.** 2·(BLINK_MAX+1) clocks. After reset the LED is dark for the first half period.
- **Breathe period.** 2·(2^B-1) PWM periods.
- **Output behaviour.** `led_out` is glitch-free: it changes only at `clk_in` edges, and duty changes only at period boundaries.

## Structure
- **Package `rgb_pkg`:**
  - `typedef enum logic [1:0] {MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BREATHE} rgb_mode_t`.
  - `typedef struct packed {logic [2:0] color; rgb_mode_t mode;}` (level is carried separately, because it depends on B).
  - Colour bit-index constants `RGB_R=0`, `RGB_G=1`, `RGB_B=2`.
- **Top (`rgb_pwm_ctr`):** holds the shared timebase (prescaler, `pwm_cnt`, blink counter, breathe ramp) and the config decode.
- **Sub-module `rgb_pwm_chan`:** one instance per LED, generated N_LEDS times. It contains the shadow/active registers, the duty mux, the comparator and the output register.

## Test plan
Bench parameters: CLK_FREQ_HZ=1024, B=4, PWM_HZ=64 (PWM_DIV=1, period 16 clocks), BLINK_HZ=8 (BLINK_MAX=63), N_LEDS=2.

1. Reset, then no writes → `led_out` = 0 and `cfg_ready` = 1 from the first edge after release.
2. Write LED0 color=3'b001, SOLID, level=4 mid-period → `led_out[0]` stays 0 until the boundary. From the next period it is high 4 of every 16 clocks, with bits [5:1] = 0.
3. Write LED1 color=3'b111, BLINK, level=15 → `led_out[5:3]` = 7 for 15 of 16 clocks during `blink_ph`=1 and 0 for the entire `blink_ph`=0 half. Each half is 64 clocks.
4. Write LED0 BREATHE, level=15 → per-period high count is `(ramp*15)>>4`: 0,0,1,2,3,...,14 rising, then falling. Full breathe cycle is 30 periods (480 clocks).
5. Two writes to LED0 in one period (level 2, then level 9), plus one write with idx=1 on the exact boundary cycle → LED0 uses 9 next period; LED1 changes one period later.
6. Assert `reset` mid-period while both LEDs are lit → `led_out` = 0 asynchronously, before the next edge. After release both LEDs stay dark (mode OFF) until rewritten.
